// File: rtl/apb_pkg.sv
// Shared APB definitions: completer FSM states and the address-region / PPROT mapping
// used by both the bridge and the memory completer.
package apb_pkg;

    localparam int unsigned APB_ADDR_WIDTH = 32;
    localparam int unsigned APB_DATA_WIDTH = 32;
    localparam int unsigned PROT_WIDTH     = 3;

    // Bit positions inside both the region field and pprot
    localparam int unsigned REGION_PRIV_BIT   = 0;
    localparam int unsigned REGION_NONSEC_BIT = 1;
    localparam int unsigned REGION_INSTR_BIT  = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ABORT  = 2'd2
    } state_t;

    // Top three address bits name the pprot attributes a region demands
    function automatic logic [PROT_WIDTH-1:0] required_pprot(input logic [APB_ADDR_WIDTH-1:0] addr);
        logic [PROT_WIDTH-1:0] r;
        r                    = '0;
        r[REGION_INSTR_BIT]  = addr[APB_ADDR_WIDTH-1];
        r[REGION_NONSEC_BIT] = addr[APB_ADDR_WIDTH-2];
        r[REGION_PRIV_BIT]   = addr[APB_ADDR_WIDTH-3];
        return r;
    endfunction

    function automatic logic region_violation(input logic [PROT_WIDTH-1:0] region,
                                              input logic [PROT_WIDTH-1:0] pprot);
        return |(region & ~pprot);
    endfunction

    function automatic logic prot_violation(input logic [APB_ADDR_WIDTH-1:0] addr,
                                            input logic [PROT_WIDTH-1:0]     pprot);
        return region_violation(required_pprot(addr), pprot);
    endfunction

endpackage

// File: rtl/apb_if.sv
// APB4 bus bundle between the bridge (master) and a completer (slave).
interface apb_if
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [PROT_WIDTH-1:0] pprot;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [STRB_W-1:0]     pstrb;
    logic                  pready;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pprot, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pprot, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_strb_mem.sv
// Word-wide register array with async clear, combinational read and byte-strobed write.
module apb_strb_mem #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          we,
    input  logic [$clog2(DEPTH)-1:0]      widx,
    input  logic [DATA_WIDTH-1:0]         wdata,
    input  logic [DATA_WIDTH/8-1:0]       wstrb,
    input  logic [$clog2(DEPTH)-1:0]      ridx,
    output logic [DATA_WIDTH-1:0]         rdata
);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (wstrb[b]) begin
                    mem_q[widx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem_q[ridx];

endmodule

// File: rtl/apb_mem_completer.sv
// APB4 completer: register memory with wait states, byte strobes, PPROT region checks
// and an ABORT response when psel drops before pready.
module apb_mem_completer
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_DEPTH   = 16,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic pclk,
    input  logic presetn,
    apb_if.slave apb
);
    localparam int unsigned STRB_W    = DATA_WIDTH / 8;
    localparam int unsigned IDX_W     = ADDR_WIDTH - 4;
    localparam int unsigned MEM_IDX_W = $clog2(MEM_DEPTH);
    localparam int unsigned CNT_W     = 4;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic [MEM_IDX_W-1:0]   idx_q, idx_d;
    logic                   pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0]  pwdata_q, pwdata_d;
    logic [STRB_W-1:0]      pstrb_q, pstrb_d;
    logic [DATA_WIDTH-1:0]  prdata_q, prdata_d;
    logic                   pready_q, pready_d;
    logic                   pslverr_q, pslverr_d;

    logic [IDX_W-2:0]       idx_full_c;
    logic [MEM_IDX_W-1:0]   mem_idx_c;
    logic                   err_c;
    logic [DATA_WIDTH-1:0]  mem_rdata_c;
    logic                   mem_we_c;
    logic [CNT_W-1:0]       cnt_inc_c;

    // Decode of the live setup-phase address
    assign idx_full_c = apb.paddr[ADDR_WIDTH-4:2];
    assign mem_idx_c  = MEM_IDX_W'(idx_full_c);
    assign err_c      = (apb.paddr[1:0] != 2'b00)
                      | (32'(idx_full_c) >= MEM_DEPTH)
                      | region_violation(apb.paddr[ADDR_WIDTH-1 -: PROT_WIDTH], apb.pprot);

    assign cnt_inc_c = cnt_q + CNT_W'(1);
    assign mem_we_c  = (state_q == ST_ACCESS) & pready_q & apb.psel & apb.penable
                     & pwrite_q & ~err_q;

    apb_strb_mem #(
        .DEPTH      (MEM_DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk   (pclk),
        .rst_n (presetn),
        .we    (mem_we_c),
        .widx  (idx_q),
        .wdata (pwdata_q),
        .wstrb (pstrb_q),
        .ridx  (mem_idx_c),
        .rdata (mem_rdata_c)
    );

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            idx_q     <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            idx_q     <= idx_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
        end
    end

    // Next state; pready/pslverr are computed one cycle ahead so they leave a flop
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        idx_d     = idx_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        prdata_d  = prdata_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (apb.psel && !apb.penable) begin
                    state_d   = ST_ACCESS;
                    cnt_d     = '0;
                    err_d     = err_c;
                    idx_d     = mem_idx_c;
                    pwrite_d  = apb.pwrite;
                    pwdata_d  = apb.pwdata;
                    pstrb_d   = apb.pstrb;
                    prdata_d  = (err_c || apb.pwrite) ? '0 : mem_rdata_c;
                    pready_d  = (WAIT_STATES == 0);
                    pslverr_d = (WAIT_STATES == 0) && err_c;
                end
            end
            ST_ACCESS: begin
                if (pready_q) begin
                    if (apb.psel && apb.penable) begin
                        state_d = ST_IDLE;
                    end else begin
                        pready_d  = 1'b1;
                        pslverr_d = err_q;
                    end
                end else if (!apb.psel) begin
                    state_d   = ST_ABORT;
                    prdata_d  = '0;
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                end else if (apb.penable) begin
                    cnt_d     = cnt_inc_c;
                    pready_d  = (32'(cnt_inc_c) == WAIT_STATES);
                    pslverr_d = pready_d && err_q;
                end
            end
            ST_ABORT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign apb.pready  = pready_q;
    assign apb.prdata  = prdata_q;
    assign apb.pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_mem_completer.sv
// Bench for apb_mem_completer: two instances (0 and 3 wait states) on a shared driver,
// checked every cycle against a transfer-level model of memory and response timing.
module tb_apb_mem_completer;
    import apb_pkg::*;

    localparam int unsigned DEPTH = 16;

    logic        pclk = 1'b0;
    logic        presetn;
    logic        sel3;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [2:0]  pprot;
    logic [3:0]  pstrb;

    always #5 pclk = ~pclk;

    apb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
    apb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus3 ();

    assign bus0.psel    = psel & ~sel3;
    assign bus0.penable = penable & ~sel3;
    assign bus0.pwrite  = pwrite;
    assign bus0.paddr   = paddr;
    assign bus0.pprot   = pprot;
    assign bus0.pwdata  = pwdata;
    assign bus0.pstrb   = pstrb;
    assign bus3.psel    = psel & sel3;
    assign bus3.penable = penable & sel3;
    assign bus3.pwrite  = pwrite;
    assign bus3.paddr   = paddr;
    assign bus3.pprot   = pprot;
    assign bus3.pwdata  = pwdata;
    assign bus3.pstrb   = pstrb;

    apb_mem_completer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH), .WAIT_STATES(0))
        dut0 (.pclk(pclk), .presetn(presetn), .apb(bus0));
    apb_mem_completer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH), .WAIT_STATES(3))
        dut3 (.pclk(pclk), .presetn(presetn), .apb(bus3));

    wire        act_pready  = sel3 ? bus3.pready  : bus0.pready;
    wire        act_pslverr = sel3 ? bus3.pslverr : bus0.pslverr;
    wire [31:0] act_prdata  = sel3 ? bus3.prdata  : bus0.prdata;
    wire        oth_pready  = sel3 ? bus0.pready  : bus3.pready;

    int n_vec = 0;
    int n_err = 0;

    logic        exp_valid   = 1'b0;
    logic        exp_pready  = 1'b0;
    logic        exp_pslverr = 1'b0;
    logic [31:0] exp_prdata  = '0;

    logic [31:0] mdl_mem [2][DEPTH];
    logic [31:0] mdl_last [2];

    logic        obs_seen;
    logic        obs_err;
    logic [31:0] obs_prdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Every cycle: selected completer must match the model, idle one must stay quiet
    always @(negedge pclk) begin
        if (exp_valid) begin
            chk("pready",  32'(act_pready),  32'(exp_pready));
            chk("pslverr", 32'(act_pslverr), 32'(exp_pslverr));
            chk("prdata",  act_prdata,       exp_prdata);
            chk("idle_pready", 32'(oth_pready), 32'd0);
            if (act_pready) begin
                obs_seen   = 1'b1;
                obs_err    = act_pslverr;
                obs_prdata = act_prdata;
            end
        end
    end

    function automatic bit mdl_err(input logic [31:0] a, input logic [2:0] p);
        bit e;
        e = (a[1:0] != 2'b00) || (int'(a[28:2]) >= int'(DEPTH));
        for (int i = 0; i < 3; i++) begin
            if (a[29+i] && !p[i]) e = 1'b1;
        end
        return e;
    endfunction

    task automatic clear_model();
        for (int d = 0; d < 2; d++) begin
            mdl_last[d] = '0;
            for (int i = 0; i < int'(DEPTH); i++) mdl_mem[d][i] = '0;
        end
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    // One transfer, entered and left at 1 time unit after a rising edge
    task automatic xfer(input bit s3, input bit wr, input logic [31:0] a, input logic [2:0] p,
                        input logic [31:0] wd, input logic [3:0] st, input int abort_k);
        int          ws;
        int          d;
        int          idx;
        bit          e;
        logic [31:0] rd;
        ws = s3 ? 3 : 0;
        d  = s3 ? 1 : 0;
        sel3 = s3;
        exp_prdata  = mdl_last[d];
        exp_pready  = 1'b0;
        exp_pslverr = 1'b0;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pprot = p; pwdata = wd; pstrb = st;
        e   = mdl_err(a, p);
        idx = int'(a[28:2]);
        rd  = (!wr && !e) ? mdl_mem[d][idx] : 32'h0;
        obs_seen = 1'b0; obs_err = 1'b0; obs_prdata = 32'hX;
        @(posedge pclk);
        #1;
        penable = 1'b1;
        exp_prdata  = rd;
        mdl_last[d] = rd;
        for (int k = 0; k <= ws; k++) begin
            exp_pready  = (k == ws);
            exp_pslverr = (k == ws) && e;
            // captured copies must win over whatever the bus now carries
            paddr = $urandom; pwdata = $urandom; pstrb = 4'($urandom); pwrite = 1'($urandom);
            pprot = 3'($urandom);
            if (k == abort_k) begin
                psel = 1'b0; penable = 1'b0;
                @(posedge pclk);
                #1;
                exp_pready = 1'b1; exp_pslverr = 1'b1; exp_prdata = '0; mdl_last[d] = '0;
                @(posedge pclk);
                #1;
                exp_pready = 1'b0; exp_pslverr = 1'b0;
                return;
            end
            @(posedge pclk);
            if (k == ws && wr && !e) begin
                for (int b = 0; b < 4; b++) begin
                    if (st[b]) mdl_mem[d][idx][8*b +: 8] = wd[8*b +: 8];
                end
            end
            #1;
        end
        psel = 1'b0; penable = 1'b0;
        exp_pready = 1'b0; exp_pslverr = 1'b0;
    endtask

    initial begin
        logic [2:0]  bad_prot [3];
        logic [31:0] a;
        bit          s3, wr;
        int          r, idx, ab;

        bad_prot[0] = 3'b110; bad_prot[1] = 3'b101; bad_prot[2] = 3'b011;
        presetn = 1'b0; sel3 = 1'b0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pprot = '0; pwdata = '0; pstrb = '0;
        clear_model();
        repeat (2) @(posedge pclk);
        #1;
        chk("rst_pready0",  32'(bus0.pready),  32'd0);
        chk("rst_pslverr0", 32'(bus0.pslverr), 32'd0);
        chk("rst_prdata3",  bus3.prdata,       32'd0);
        presetn = 1'b1;
        gap(1);
        exp_valid = 1'b1;

        xfer(1'b0, 1'b0, 32'h4, 3'b000, 32'h0, 4'h0, -1);
        chk("rst_rd_seen", 32'(obs_seen), 32'd1);
        chk("rst_rd_data", obs_prdata, 32'h0);
        chk("rst_rd_err",  32'(obs_err), 32'd0);

        xfer(1'b0, 1'b1, 32'h8, 3'b000, 32'hDEADBEEF, 4'hF, -1);
        xfer(1'b0, 1'b1, 32'h8, 3'b000, 32'h00000011, 4'h1, -1);
        xfer(1'b0, 1'b0, 32'h8, 3'b000, 32'h0, 4'h0, -1);
        chk("strb_rd_data", obs_prdata, 32'hDEADBE11);
        chk("strb_rd_err",  32'(obs_err), 32'd0);

        xfer(1'b0, 1'b1, 32'hE0000004, 3'b111, 32'h12345678, 4'hF, -1);
        xfer(1'b0, 1'b0, 32'hE0000004, 3'b111, 32'h0, 4'h0, -1);
        chk("prot_ok_data", obs_prdata, 32'h12345678);
        chk("prot_ok_err",  32'(obs_err), 32'd0);
        for (int i = 0; i < 3; i++) begin
            xfer(1'b0, 1'b0, 32'hE0000004, bad_prot[i], 32'h0, 4'h0, -1);
            chk("prot_bad_err",  32'(obs_err), 32'd1);
            chk("prot_bad_data", obs_prdata, 32'h0);
            xfer(1'b0, 1'b1, 32'hE0000004, bad_prot[i], 32'hFFFFFFFF, 4'hF, -1);
            chk("prot_bad_wr_err", 32'(obs_err), 32'd1);
            xfer(1'b0, 1'b0, 32'hE0000004, 3'b111, 32'h0, 4'h0, -1);
            chk("prot_bad_wr_kept", obs_prdata, 32'h12345678);
        end

        xfer(1'b0, 1'b0, 32'h3, 3'b000, 32'h0, 4'h0, -1);
        chk("unaligned_err",  32'(obs_err), 32'd1);
        chk("unaligned_data", obs_prdata, 32'h0);
        xfer(1'b0, 1'b0, 32'h40, 3'b000, 32'h0, 4'h0, -1);
        chk("range_err",  32'(obs_err), 32'd1);
        chk("range_data", obs_prdata, 32'h0);

        xfer(1'b1, 1'b1, 32'hC, 3'b000, 32'hA5A5A5A5, 4'hF, -1);
        xfer(1'b1, 1'b0, 32'hC, 3'b000, 32'h0, 4'h0, -1);
        chk("ws3_rd_data", obs_prdata, 32'hA5A5A5A5);
        xfer(1'b1, 1'b1, 32'hC, 3'b000, 32'h5A5A5A5A, 4'hF, 1);
        chk("abort_seen", 32'(obs_seen), 32'd1);
        chk("abort_err",  32'(obs_err), 32'd1);
        chk("abort_data", obs_prdata, 32'h0);
        xfer(1'b1, 1'b0, 32'hC, 3'b000, 32'h0, 4'h0, -1);
        chk("abort_no_commit", obs_prdata, 32'hA5A5A5A5);

        repeat (300) begin
            s3  = 1'($urandom);
            wr  = 1'($urandom);
            r   = $urandom_range(0, 9);
            idx = (r == 0) ? $urandom_range(16, 20) : $urandom_range(0, 15);
            a   = {3'($urandom), 27'(idx), 2'b00};
            if (r == 1) a[1:0] = 2'($urandom_range(1, 3));
            ab  = (s3 && r == 2) ? $urandom_range(0, 2) : -1;
            xfer(s3, wr, a, (r >= 5) ? 3'b111 : 3'($urandom), $urandom, 4'($urandom), ab);
            gap($urandom_range(0, 2));
        end

        // Reset in the middle of a wait-stated read
        xfer(1'b1, 1'b1, 32'h10, 3'b000, 32'h00000077, 4'hF, -1);
        sel3 = 1'b1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h10; pprot = 3'b000;
        @(posedge pclk);
        #1;
        penable = 1'b1;
        exp_prdata = 32'h77;
        @(posedge pclk);
        #2;
        chk("pre_rst_prdata", bus3.prdata, 32'h77);
        presetn   = 1'b0;
        exp_valid = 1'b0;
        #1;
        chk("mid_rst_pready",  32'(bus3.pready),  32'd0);
        chk("mid_rst_pslverr", 32'(bus3.pslverr), 32'd0);
        chk("mid_rst_prdata",  bus3.prdata,       32'd0);
        psel = 1'b0; penable = 1'b0;
        clear_model();
        @(posedge pclk);
        #1;
        presetn = 1'b1;
        exp_prdata = '0; exp_pready = 1'b0; exp_pslverr = 1'b0;
        exp_valid  = 1'b1;
        xfer(1'b1, 1'b0, 32'h10, 3'b000, 32'h0, 4'h0, -1);
        chk("rst_cleared3", obs_prdata, 32'h0);
        xfer(1'b0, 1'b0, 32'h8, 3'b000, 32'h0, 4'h0, -1);
        chk("rst_cleared0", obs_prdata, 32'h0);
        gap(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
